// File: rtl/bit_counter_param.sv
// Multi-mode bit counter: scans a WIDTH-bit operand K bits per cycle and reports
// the ones, zeros, leading-zero or trailing-zero count through a start/done handshake.
module bit_counter_param #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned K     = 1,
  localparam int unsigned RW   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  output logic [RW-1:0]    result,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic [1:0]       mode_q;
  logic [RW-1:0]    cnt_q;
  logic [RW-1:0]    rem_q;
  logic             busy_q;
  logic             done_q;

  logic [K-1:0]     chunk_hi;
  logic [K-1:0]     chunk_lo;
  logic [RW-1:0]    pop_lo;
  logic [RW-1:0]    lz_hi;
  logic [RW-1:0]    tz_lo;
  logic             run_fin;

  // Per-chunk counts; lz_hi/tz_lo are only consumed when the chunk holds a 1.
  always_comb begin
    chunk_hi = data_q[WIDTH-1 -: K];
    chunk_lo = data_q[K-1:0];
    pop_lo   = '0;
    lz_hi    = '0;
    tz_lo    = '0;
    for (int unsigned i = 0; i < K; i++) begin
      if (chunk_lo[i]) pop_lo = pop_lo + RW'(1);
      if (chunk_hi[i]) lz_hi = RW'(K - 1 - i);
    end
    for (int unsigned i = K; i > 0; i--) begin
      if (chunk_lo[i-1]) tz_lo = RW'(i - 1);
    end
  end

  always_comb begin
    run_fin = 1'b0;
    unique case (mode_q)
      2'b10:   run_fin = (|chunk_hi) || (rem_q == RW'(K));
      2'b11:   run_fin = (|chunk_lo) || (rem_q == RW'(K));
      default: run_fin = (data_q == '0);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      data_q  <= '0;
      mode_q  <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            data_q  <= data_in;
            mode_q  <= mode;
            cnt_q   <= '0;
            rem_q   <= RW'(WIDTH);
            state_q <= StRun;
            busy_q  <= 1'b1;
          end
        end
        StRun: begin
          case (mode_q)
            2'b10: begin
              if (|chunk_hi) begin
                cnt_q <= cnt_q + lz_hi;
              end else begin
                cnt_q  <= cnt_q + RW'(K);
                data_q <= data_q << K;
                rem_q  <= rem_q - RW'(K);
              end
            end
            2'b11: begin
              if (|chunk_lo) begin
                cnt_q <= cnt_q + tz_lo;
              end else begin
                cnt_q  <= cnt_q + RW'(K);
                data_q <= data_q >> K;
                rem_q  <= rem_q - RW'(K);
              end
            end
            default: begin
              if (data_q != '0) begin
                cnt_q  <= cnt_q + pop_lo;
                data_q <= data_q >> K;
              end
            end
          endcase
          if (run_fin) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          if (!start) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Zeros count is derived from the ones count gathered in RUN.
  assign result = (mode_q == 2'b01) ? RW'(WIDTH) - cnt_q : cnt_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_bit_counter_param.sv
// Randomised self-checking bench for bit_counter_param (8x1 and 16x2 instances)
// against a latency/result model derived from plain bit arithmetic.
module tb_bit_counter_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a [2];
  logic [1:0]  mode_a  [2];
  logic [15:0] data_a  [2];
  logic        busy_a  [2];
  logic        done_a  [2];
  logic [3:0]  res8;
  logic [4:0]  res16;

  int n_cmp = 0;
  int n_err = 0;
  bit armed = 1'b0;

  int ph    [2];  // 0 idle, 1 run, 2 done
  int left  [2];
  int eres  [2];
  bit known [2];

  always #5 clk = ~clk;

  bit_counter_param #(.WIDTH(8), .K(1)) u_dut8 (
    .clk(clk), .reset(reset), .start(start_a[0]), .mode(mode_a[0]),
    .data_in(data_a[0][7:0]), .result(res8), .busy(busy_a[0]), .done(done_a[0])
  );

  bit_counter_param #(.WIDTH(16), .K(2)) u_dut16 (
    .clk(clk), .reset(reset), .start(start_a[1]), .mode(mode_a[1]),
    .data_in(data_a[1]), .result(res16), .busy(busy_a[1]), .done(done_a[1])
  );

  function automatic int wid(input int i);
    return (i == 0) ? 8 : 16;
  endfunction

  function automatic int kof(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic int res_of(input int i);
    return (i == 0) ? int'(res8) : int'(res16);
  endfunction

  function automatic int ref_res(input logic [15:0] d, input logic [1:0] m, input int w);
    int ones = 0;
    int lz = w;
    int tz = w;
    for (int b = 0; b < w; b++) if (d[b]) begin ones++; lz = w - 1 - b; end
    for (int b = w - 1; b >= 0; b--) if (d[b]) tz = b;
    case (m)
      2'd0:    return ones;
      2'd1:    return w - ones;
      2'd2:    return lz;
      default: return tz;
    endcase
  endfunction

  function automatic int ref_lat(input logic [15:0] d, input logic [1:0] m, input int w,
                                 input int k);
    int hi = -1;
    int z;
    for (int b = 0; b < w; b++) if (d[b]) hi = b;
    if (m >= 2'd2) begin
      z = ref_res(d, m, w);
      return (hi < 0) ? w / k : z / k + 1;
    end
    return (hi < 0) ? 1 : (hi + k) / k + 1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle-level expectation: latency countdown computed at the load edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        ph[i] <= 0; left[i] <= 0; eres[i] <= 0; known[i] <= 1'b1;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (ph[i])
          0: if (start_a[i]) begin
            ph[i]    <= 1;
            known[i] <= 1'b0;
            left[i]  <= ref_lat(data_a[i], mode_a[i], wid(i), kof(i));
            eres[i]  <= ref_res(data_a[i], mode_a[i], wid(i));
          end
          1: begin
            left[i] <= left[i] - 1;
            if (left[i] == 1) ph[i] <= 2;
          end
          default: if (!start_a[i]) ph[i] <= 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (armed && !reset) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("busy[%0d]", i), int'(busy_a[i]), int'(ph[i] == 1));
        chk($sformatf("done[%0d]", i), int'(done_a[i]), int'(ph[i] == 2));
        if (ph[i] == 2 || known[i]) chk($sformatf("result[%0d]", i), res_of(i), eres[i]);
      end
    end
  end

  task automatic run_op(input int i, input logic [15:0] d, input logic [1:0] m, input int hold,
                        output int lat, output int r);
    bit got = 1'b0;
    @(negedge clk);
    start_a[i] = 1'b1; data_a[i] = d; mode_a[i] = m;
    @(posedge clk); #1;
    if (hold == 0) start_a[i] = 1'b0;
    lat = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      data_a[i] = 16'($urandom);
      mode_a[i] = 2'($urandom);
      @(posedge clk); #1;
      lat++;
      if (done_a[i]) got = 1'b1;
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL timeout[%0d]: done not seen, expected within 40 edges", i);
    end
    r = res_of(i);
    repeat (hold) @(posedge clk);
    #1;
    if (hold > 0) chk($sformatf("held_done[%0d]", i), int'(done_a[i]), 1);
    @(negedge clk);
    start_a[i] = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("to_idle[%0d]", i), int'(done_a[i]), 0);
  endtask

  task automatic dir_op(input int i, input logic [15:0] d, input logic [1:0] m, input int hold,
                        input int exp_r, input int exp_l);
    int lat;
    int r;
    run_op(i, d, m, hold, lat, r);
    chk($sformatf("dir_lat[%0d] d=%h m=%0d", i, d, m), lat, exp_l);
    chk($sformatf("dir_res[%0d] d=%h m=%0d", i, d, m), r, exp_r);
  endtask

  task automatic abort_op(input int i, input logic [15:0] d, input logic [1:0] m, input int n,
                          input bit pre);
    @(negedge clk);
    start_a[i] = 1'b1; data_a[i] = d; mode_a[i] = m;
    @(posedge clk); #1;
    start_a[i] = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    if (pre) chk($sformatf("abort_pre_busy[%0d]", i), int'(busy_a[i]), 1);
    #2 reset = 1'b1;
    #1;
    chk($sformatf("abort_busy[%0d]", i), int'(busy_a[i]), 0);
    chk($sformatf("abort_done[%0d]", i), int'(done_a[i]), 0);
    chk($sformatf("abort_result[%0d]", i), res_of(i), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int i;
    int lat;
    int r;
    int sel;
    int hold;
    logic [15:0] d;
    logic [1:0]  m;

    reset = 1'b1;
    for (int j = 0; j < 2; j++) begin
      start_a[j] = 1'b0; mode_a[j] = 2'd0; data_a[j] = 16'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("rst_busy[%0d]", j), int'(busy_a[j]), 0);
      chk($sformatf("rst_done[%0d]", j), int'(done_a[j]), 0);
      chk($sformatf("rst_result[%0d]", j), res_of(j), 0);
    end
    @(negedge clk);
    reset = 1'b0;
    armed = 1'b1;

    dir_op(0, 16'h00AA, 2'd0, 3, 4, 9);
    dir_op(0, 16'h0005, 2'd0, 0, 2, 4);
    dir_op(0, 16'h0005, 2'd1, 0, 6, 4);
    dir_op(0, 16'h0010, 2'd2, 0, 3, 4);
    dir_op(0, 16'h0010, 2'd3, 2, 4, 5);
    dir_op(0, 16'h0000, 2'd0, 0, 0, 1);
    dir_op(0, 16'h0000, 2'd1, 0, 8, 1);
    dir_op(0, 16'h0000, 2'd2, 0, 8, 8);
    dir_op(1, 16'hFFFF, 2'd0, 0, 16, 9);
    dir_op(1, 16'h0100, 2'd3, 0, 8, 5);
    abort_op(0, 16'h00FF, 2'd0, 3, 1'b1);
    abort_op(1, 16'h8000, 2'd3, 2, 1'b1);

    for (int it = 0; it < 150; it++) begin
      i   = int'($urandom % 2);
      d   = 16'($urandom);
      sel = int'($urandom % 4);
      if (sel == 0) d = 16'd0;
      if (sel == 1) d = d & (d >> 3) & (d >> 7);
      if (sel == 2) d = d & (d << 5);
      m    = 2'($urandom);
      hold = ($urandom % 3 == 0) ? int'($urandom_range(1, 3)) : 0;
      run_op(i, d, m, hold, lat, r);
      chk($sformatf("rnd_lat[%0d] d=%h m=%0d", i, d, m), lat, ref_lat(d, m, wid(i), kof(i)));
      chk($sformatf("rnd_res[%0d] d=%h m=%0d", i, d, m), r, ref_res(d, m, wid(i)));
    end

    for (int it = 0; it < 6; it++) begin
      abort_op(int'($urandom % 2), 16'($urandom), 2'($urandom),
               int'($urandom_range(0, 6)), 1'b0);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
